// File: rtl/ram_io_responder_if.sv
// CPU-side byte bus plus the external TX/RX byte handshakes of the RAM/IO responder.
interface ram_io_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    // Responder side.
    modport slave (
        input  rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
    );

    // CPU and host/UART side.
    modport master (
        output rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/ram_io_responder.sv
// Byte-addressed main RAM plus one I/O window (TX FIFO, RX FIFO, status byte).
module ram_io_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus
);

    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    logic [7:0]       ram_mem [RAM_BYTES];
    logic [7:0]       tx_mem  [FIFO_DEPTH];
    logic [7:0]       rx_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mem_din_q, mem_din_d;

    logic             is_io_c, ram_we_c;
    logic [2:0]       io_off_c;
    logic             tx_full_c, tx_pop_c, tx_wr_req_c, tx_push_c;
    logic             rx_full_c, rx_nonempty_c, rx_rd_req_c, rx_pop_c, rx_push_c;
    logic             stat_rd_c;
    logic             unused_addr_c;

    assign is_io_c       = (bus.mem_a[17:16] == 2'b11);
    assign io_off_c      = bus.mem_a[2:0];
    assign ram_we_c      = bus.rdy && bus.mem_wr && !is_io_c;
    assign unused_addr_c = ^bus.mem_a[31:18];

    assign tx_full_c     = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign tx_pop_c      = (tx_cnt_q != '0) && bus.tx_ready;
    assign tx_wr_req_c   = bus.rdy && is_io_c && bus.mem_wr && (io_off_c == 3'd0);
    // A full TX FIFO still takes the byte when the sink frees a slot this cycle.
    assign tx_push_c     = tx_wr_req_c && (!tx_full_c || tx_pop_c);

    assign rx_full_c     = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign rx_nonempty_c = (rx_cnt_q != '0);
    assign rx_rd_req_c   = bus.rdy && is_io_c && !bus.mem_wr && (io_off_c == 3'd0);
    assign rx_pop_c      = rx_rd_req_c && rx_nonempty_c;
    assign rx_push_c     = bus.rx_valid && !rx_full_c;
    assign stat_rd_c     = bus.rdy && is_io_c && !bus.mem_wr && (io_off_c == 3'd4);

    assign bus.mem_din        = mem_din_q;
    assign bus.io_buffer_full = tx_full_c;
    assign bus.tx_valid       = (tx_cnt_q != '0);
    assign bus.tx_data        = tx_mem[tx_rd_q];
    assign bus.rx_ready       = !rx_full_c;

    // Next-state for pointers, counts, sticky overflow and read data.
    always_comb begin
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        tx_cnt_d  = tx_cnt_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
        rx_cnt_d  = rx_cnt_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
        ovf_d     = ovf_q;
        mem_din_d = mem_din_q;

        if (tx_push_c) tx_wr_d = tx_wr_q + PTR_W'(1);
        if (tx_pop_c)  tx_rd_d = tx_rd_q + PTR_W'(1);
        if (rx_push_c) rx_wr_d = rx_wr_q + PTR_W'(1);
        if (rx_pop_c)  rx_rd_d = rx_rd_q + PTR_W'(1);

        if (tx_wr_req_c && tx_full_c && !tx_pop_c) begin
            ovf_d = 1'b1;
        end else if (stat_rd_c) begin
            ovf_d = 1'b0;
        end

        if (bus.rdy) begin
            if (bus.mem_wr) begin
                mem_din_d = 8'h00;
            end else if (!is_io_c) begin
                mem_din_d = ram_mem[bus.mem_a[ADDR_WIDTH-1:0]];
            end else if (io_off_c == 3'd0) begin
                mem_din_d = rx_nonempty_c ? rx_mem[rx_rd_q] : 8'h00;
            end else if (io_off_c == 3'd4) begin
                mem_din_d = {5'b0, ovf_q, rx_nonempty_c, tx_full_c};
            end else begin
                mem_din_d = 8'h00;
            end
        end
    end

    // Control state; reset empties both FIFOs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            mem_din_q <= 8'h00;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            ovf_q     <= ovf_d;
            mem_din_q <= mem_din_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (ram_we_c)  ram_mem[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.mem_dout;
        if (tx_push_c) tx_mem[tx_wr_q] <= bus.mem_dout;
        if (rx_push_c) rx_mem[rx_wr_q] <= bus.rx_data;
    end

endmodule
